controle_memoria_instrucao: RTL and testbench

//  Sequencer/arbiter for the single-port instruction memory. Owns the memory's

---
 rtl/controle_memoria_instrucao.sv | 155 +++++++++++++++
 tb/tb_controle_memoria_instrucao.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_memoria_instrucao.sv
`default_nettype none
// ============================================================================
//  Module   : controle_memoria_instrucao
//  Purpose  : Sequencer/arbiter for the single-port instruction memory.
//             Shares the memory port between the program loader (writes) and
//             CPU instruction fetch (reads, 3-cycle fixed latency). Fetch is
//             blocked once a HALT opcode has been delivered.
//  Revision : 1.0 - initial release
// ============================================================================
module controle_memoria_instrucao #(
   parameter int DEPTH  = 71,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_mode,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              ld_err,
   output logic [ADDR_W-1:0] load_count,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_instr,
   output logic              fetch_fault,
   output logic              halted,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [5:0]        c_halt_op  = 6'b111110;
   localparam logic [31:0]       c_depth_32 = 32'(DEPTH);
   localparam logic [ADDR_W-1:0] c_depth_a  = ADDR_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RD   = 2'd2,
      S_CAP  = 2'd3
   } state_t;

   state_t            r_state;
   logic [31:0]       r_fetch_addr;
   logic [ADDR_W-1:0] r_load_count;
   logic              r_fetch_valid;
   logic [DATA_W-1:0] r_fetch_instr;
   logic              r_fetch_fault;
   logic              r_halted;

   logic w_ld_in_range;
   logic w_fetch_oob;
   logic w_rdata_halt;

   assign w_ld_in_range = (ld_addr < c_depth_a);
   // Any set bit above the memory range (including the top of the 32-bit PC) faults
   assign w_fetch_oob   = (r_fetch_addr >= c_depth_32);
   assign w_rdata_halt  = (mem_rdata[DATA_W-1 -: 6] == c_halt_op);

   assign load_count  = r_load_count;
   assign fetch_valid = r_fetch_valid;
   assign fetch_instr = r_fetch_instr;
   assign fetch_fault = r_fetch_fault;
   assign halted      = r_halted;

   // Memory port mux: loader writes pass straight through in LOAD, fetch address in RD
   always_comb begin
      ld_ready  = 1'b0;
      ld_err    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         S_LOAD: begin
            ld_ready = load_mode;
            if (ld_valid && load_mode) begin
               if (w_ld_in_range) begin
                  mem_we    = 1'b1;
                  mem_addr  = ld_addr;
                  mem_wdata = ld_data;
               end else begin
                  ld_err = 1'b1;
               end
            end
         end
         S_RD: begin
            mem_addr = r_fetch_addr[ADDR_W-1:0];
         end
         default: begin
         end
      endcase
   end

   // Sequencer: arbitration in IDLE, write counting in LOAD, read/capture for fetch
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_fetch_addr  <= '0;
         r_load_count  <= '0;
         r_fetch_valid <= 1'b0;
         r_fetch_instr <= '0;
         r_fetch_fault <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         r_fetch_valid <= 1'b0;
         r_fetch_fault <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (load_mode) begin
                  r_state      <= S_LOAD;
                  r_halted     <= 1'b0;
                  r_load_count <= '0;
               end else if (fetch_req && !r_halted) begin
                  r_state      <= S_RD;
                  r_fetch_addr <= fetch_addr;
               end
            end
            S_LOAD: begin
               // Only in-range writes reach the memory, so only those are counted
               if (mem_we && (r_load_count < c_depth_a)) begin
                  r_load_count <= r_load_count + ADDR_W'(1);
               end
               if (!load_mode) begin
                  r_state <= S_IDLE;
               end
            end
            S_RD: begin
               r_state <= S_CAP;
            end
            S_CAP: begin
               r_state       <= S_IDLE;
               r_fetch_valid <= 1'b1;
               if (w_fetch_oob) begin
                  r_fetch_instr <= '0;
                  r_fetch_fault <= 1'b1;
               end else begin
                  r_fetch_instr <= mem_rdata;
                  if (w_rdata_halt) begin
                     r_halted <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_controle_memoria_instrucao.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controle_memoria_instrucao
//  Purpose  : Self-checking bench for controle_memoria_instrucao with a
//             registered-read memory and an abstract reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controle_memoria_instrucao;

   localparam int         DEPTH  = 71;
   localparam int         ADDR_W = 7;
   localparam int         DATA_W = 32;
   localparam logic [5:0] c_halt_op = 6'b111110;

   logic              clock = 1'b0;
   logic              reset;
   logic              load_mode;
   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              ld_err;
   logic [ADDR_W-1:0] load_count;
   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_instr;
   logic              fetch_fault;
   logic              halted;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   always #5 clock = ~clock;

   controle_memoria_instrucao #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .load_mode   (load_mode),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .ld_err      (ld_err),
      .load_count  (load_count),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_fault (fetch_fault),
      .halted      (halted),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // Single-port memory, read data registered one edge after the address
   logic [DATA_W-1:0] mem_array [0:(1<<ADDR_W)-1];
   always @(posedge clock) begin
      if (mem_we) mem_array[mem_addr] <= mem_wdata;
      mem_rdata <= mem_array[mem_addr];
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
   bit                ref_halted;
   int                ref_count;
   int                n_tests = 0;
   int                n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word(input bit allow_halt);
      logic [DATA_W-1:0] w;
      w = $urandom;
      if (allow_halt && ($urandom_range(0, 5) == 0)) w[31:26] = c_halt_op;
      else if (w[31:26] == c_halt_op) w[31] = 1'b0;
      return w;
   endfunction

   task automatic check_all_zero(input string pfx);
      check({pfx, "_fetch_valid"}, 32'(fetch_valid), 32'd0);
      check({pfx, "_fetch_fault"}, 32'(fetch_fault), 32'd0);
      check({pfx, "_fetch_instr"}, fetch_instr, 32'd0);
      check({pfx, "_halted"},      32'(halted), 32'd0);
      check({pfx, "_load_count"},  32'(load_count), 32'd0);
      check({pfx, "_ld_ready"},    32'(ld_ready), 32'd0);
      check({pfx, "_ld_err"},      32'(ld_err), 32'd0);
      check({pfx, "_mem_we"},      32'(mem_we), 32'd0);
      check({pfx, "_mem_addr"},    32'(mem_addr), 32'd0);
      check({pfx, "_mem_wdata"},   mem_wdata, 32'd0);
   endtask

   // Called from IDLE; one edge later the controller owns the loader path
   task automatic enter_load();
      load_mode = 1'b1;
      @(negedge clock);
      ref_halted = 1'b0;
      ref_count  = 0;
      check("load_halted_clr", 32'(halted), 32'd0);
      check("load_count_clr",  32'(load_count), 32'd0);
      check("load_ld_ready",   32'(ld_ready), 32'd1);
   endtask

   task automatic leave_load();
      load_mode = 1'b0;
      #1;
      check("leave_ld_ready", 32'(ld_ready), 32'd0);
      @(negedge clock);
   endtask

   task automatic write_word(input int addr, input logic [DATA_W-1:0] data);
      bit oob;
      oob      = (addr >= DEPTH);
      ld_valid = 1'b1;
      ld_addr  = addr[ADDR_W-1:0];
      ld_data  = data;
      #1;
      check("wr_ld_ready", 32'(ld_ready), 32'd1);
      check("wr_mem_we",   32'(mem_we), 32'(!oob));
      check("wr_ld_err",   32'(ld_err), 32'(oob));
      if (!oob) begin
         check("wr_mem_addr",  32'(mem_addr), addr);
         check("wr_mem_wdata", mem_wdata, data);
      end
      @(negedge clock);
      ld_valid = 1'b0;
      if (!oob) begin
         ref_mem[addr] = data;
         if (ref_count < DEPTH) ref_count++;
      end
      check("wr_load_count", 32'(load_count), ref_count);
   endtask

   // Issue one fetch; optionally raise load_mode during the read cycle
   task automatic fetch(input logic [31:0] addr, input bit lm_in_rd);
      int                cyc;
      bit                oob;
      logic [DATA_W-1:0] exp_w;
      oob   = (addr >= DEPTH);
      exp_w = '0;
      if (!oob) exp_w = ref_mem[addr[ADDR_W-1:0]];
      fetch_req  = 1'b1;
      fetch_addr = addr;
      if (ref_halted) begin
         cyc = 0;
         repeat (6) begin
            @(negedge clock);
            if (fetch_valid) cyc++;
         end
         fetch_req = 1'b0;
         check("halted_no_fetch", cyc, 32'd0);
         return;
      end
      cyc = 0;
      while (cyc < 10) begin
         @(negedge clock);
         cyc++;
         if (cyc == 1) begin
            check("rd_mem_addr", 32'(mem_addr), 32'(addr[ADDR_W-1:0]));
            check("rd_mem_we",   32'(mem_we), 32'd0);
            if (lm_in_rd) load_mode = 1'b1;
         end
         if (fetch_valid) break;
      end
      fetch_req = 1'b0;
      check("fetch_latency", cyc, 32'd3);
      check("fetch_valid",   32'(fetch_valid), 32'd1);
      check("fetch_instr",   fetch_instr, exp_w);
      check("fetch_fault",   32'(fetch_fault), 32'(oob));
      if (!oob && (exp_w[31:26] == c_halt_op)) ref_halted = 1'b1;
      check("fetch_halted",  32'(halted), 32'(ref_halted));
      if (lm_in_rd) check("lm_idle_ld_ready", 32'(ld_ready), 32'd0);
      @(negedge clock);
      check("valid_pulse", 32'(fetch_valid), 32'd0);
      check("fault_pulse", 32'(fetch_fault), 32'd0);
      check("instr_hold",  fetch_instr, exp_w);
      if (lm_in_rd) begin
         ref_halted = 1'b0;
         ref_count  = 0;
         check("lm_ld_ready",   32'(ld_ready), 32'd1);
         check("lm_halted",     32'(halted), 32'd0);
         check("lm_load_count", 32'(load_count), 32'd0);
      end
   endtask

   task automatic random_phase();
      int          a;
      int          n;
      logic [31:0] fa;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            enter_load();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
               if ($urandom_range(0, 7) == 0) a = $urandom_range(DEPTH, 127);
               else                           a = $urandom_range(0, DEPTH - 1);
               write_word(a, rand_word(1'b1));
               if ($urandom_range(0, 2) == 0) begin
                  @(negedge clock);
                  check("gap_load_count", 32'(load_count), ref_count);
               end
            end
            leave_load();
         end else begin
            case ($urandom_range(0, 9))
               0:       fa = 32'(DEPTH);
               1:       fa = $urandom;
               2:       fa = 32'($urandom_range(DEPTH, 127));
               default: fa = 32'($urandom_range(0, DEPTH - 1));
            endcase
            fetch(fa, 1'b0);
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      load_mode  = 1'b0;
      ld_valid   = 1'b0;
      ld_addr    = '0;
      ld_data    = '0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      ref_halted = 1'b0;
      ref_count  = 0;
      repeat (2) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clock);

      // Program load: fill every word, then the four-instruction program, then extras
      enter_load();
      for (int i = 0; i < DEPTH; i++) write_word(i, rand_word(1'b0));
      write_word(0, 32'h0000_0000);
      write_word(1, 32'h0400_0012);
      write_word(2, 32'h0822_1800);
      write_word(3, 32'hF800_0000);
      for (int i = 10; i < 15; i++) write_word(i, rand_word(1'b0));
      check("load_sat", 32'(load_count), 32'(DEPTH));
      leave_load();

      // Run the program up to HALT
      for (int i = 0; i < 4; i++) fetch(32'(i), 1'b0);
      check("halted_after_prog", 32'(halted), 32'd1);

      // Fetch blocked while halted; LOAD clears the halt
      fetch(32'd5, 1'b0);
      enter_load();

      // Out-of-range write is dropped
      write_word(80, 32'hDEAD_BEEF);
      write_word(4, rand_word(1'b0));
      leave_load();

      // Out-of-range fetches fault
      fetch(32'd71, 1'b0);
      fetch(32'h8000_0003, 1'b0);
      fetch(32'd127, 1'b0);

      // Loader handshake outside LOAD is ignored
      ld_valid = 1'b1;
      ld_addr  = 7'd9;
      ld_data  = 32'h1234_5678;
      #1;
      check("idle_ld_ready", 32'(ld_ready), 32'd0);
      check("idle_mem_we",   32'(mem_we), 32'd0);
      check("idle_ld_err",   32'(ld_err), 32'd0);
      @(negedge clock);
      ld_valid = 1'b0;
      fetch(32'd9, 1'b0);

      // load_mode raised mid-fetch: the fetch completes, then LOAD
      fetch(32'd2, 1'b1);
      leave_load();

      // Reset during RD discards the fetch
      fetch_req  = 1'b1;
      fetch_addr = 32'd1;
      @(negedge clock);
      check("rst_rd_mem_addr", 32'(mem_addr), 32'd1);
      reset     = 1'b1;
      fetch_req = 1'b0;
      @(negedge clock);
      check_all_zero("rst_rd");
      reset = 1'b0;
      ref_halted = 1'b0;
      ref_count  = 0;
      begin
         int seen;
         seen = 0;
         repeat (4) begin
            @(negedge clock);
            if (fetch_valid) seen++;
         end
         check("rst_rd_no_valid", seen, 32'd0);
      end

      // Reset during LOAD stops writes from the next cycle
      enter_load();
      reset = 1'b1;
      @(negedge clock);
      reset    = 1'b0;
      ld_valid = 1'b1;
      ld_addr  = 7'd7;
      ld_data  = 32'hCAFE_0007;
      #1;
      check("rst_ld_mem_we",   32'(mem_we), 32'd0);
      check("rst_ld_ld_ready", 32'(ld_ready), 32'd0);
      load_mode = 1'b0;
      ld_valid  = 1'b0;
      ref_halted = 1'b0;
      ref_count  = 0;
      @(negedge clock);
      fetch(32'd7, 1'b0);

      random_phase();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
